cache_refill_ctrl: RTL and testbench

//  Memory-side miss handler for the 2-way data cache: responds to the cache's miss, writes back a dirty

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_refill_ctrl_if.sv | 16 +
 rtl/cache_perf_cnt.sv | 29 ++
 rtl/cache_refill_ctrl.sv | 124 ++++++++++++
 tb/tb_cache_refill_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types for the data cache and its memory-side refill controller.
//   refill_state_e : refill controller state encoding
//   fill_t         : one fill write into the cache arrays (way/set/tag/data)
//   word_addr()    : rebuilds a word-aligned byte address from tag + set
package cache_pkg;

  localparam int ADDRESS_WIDTH     = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int SET_SIZE          = 8;
  localparam int TAG_SIZE          = 22;
  localparam int BYTE_OFFSET_WIDTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_REFILL,
    ST_FILL,
    ST_DONE
  } refill_state_e;

  typedef struct packed {
    logic                  way;
    logic [SET_SIZE-1:0]   set;
    logic [TAG_SIZE-1:0]   tag;
    logic [DATA_WIDTH-1:0] data;
  } fill_t;

  function automatic logic [ADDRESS_WIDTH-1:0] word_addr(
    input logic [TAG_SIZE-1:0] tag,
    input logic [SET_SIZE-1:0] set
  );
    return {tag, set, {BYTE_OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Main-memory request bus used by the refill controller.
//   req/we/addr/wdata : request side, driven by the controller (master)
//   ready/rdata       : memory accept; read data valid in the accept cycle (slave)
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  logic                     req;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/cache_perf_cnt.sv
// Miss / writeback event counters for the refill controller.
//   clk_i, rst_ni          : clock, async active-low reset
//   clr_i                  : synchronous clear of both counters
//   miss_inc_i, wb_inc_i   : one-cycle increment strobes
//   miss_cnt_o, wb_cnt_o   : 32-bit wrapping counts
module cache_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        miss_inc_i,
  input  logic        wb_inc_i,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else if (clr_i) begin
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (miss_inc_i) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (wb_inc_i)   wb_cnt_o   <= wb_cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Memory-side miss handler for the 2-way data cache. On a miss it writes
// back a dirty victim word, reads the missing word from main memory and
// issues a single fill strobe to the cache, holding the pipeline meanwhile.
//   clk_i, rst_ni           : clock, async active-low reset
//   miss_i, miss_addr_i     : miss request (level) and its byte address
//   victim_*_i              : victim way / dirty / tag / data from the cache
//   fill_*_o                : one-cycle fill write back into the cache
//   stall_o                 : pipeline hold
//   mem                     : main-memory request bus (master side)
//   perf_miss_o, perf_wb_o  : event counts; live only with CACHE_PERF_CNT_EN
//                             defined, otherwise tied to 0
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      miss_i,
  input  logic [ADDRESS_WIDTH-1:0]  miss_addr_i,
  input  logic                      victim_way_i,
  input  logic                      victim_dirty_i,
  input  logic [TAG_SIZE-1:0]       victim_tag_i,
  input  logic [DATA_WIDTH-1:0]     victim_data_i,
  output logic                      fill_valid_o,
  output logic                      fill_way_o,
  output logic [SET_SIZE-1:0]       fill_set_o,
  output logic [TAG_SIZE-1:0]       fill_tag_o,
  output logic [DATA_WIDTH-1:0]     fill_data_o,
  output logic                      stall_o,
  cache_refill_ctrl_if.master       mem,
  output logic [31:0]               perf_miss_o,
  output logic [31:0]               perf_wb_o
);

  localparam int SET_LO = BYTE_OFFSET_WIDTH;
  localparam int TAG_LO = BYTE_OFFSET_WIDTH + SET_SIZE;

  refill_state_e state_q, state_d;
  fill_t                 fill_q;     // way/set/tag captured at miss, data at read
  logic [TAG_SIZE-1:0]   wb_tag_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic                  capture;

  // Byte-in-word bits do not matter for a one-word line.
  logic unused_offset;
  assign unused_offset = ^miss_addr_i[BYTE_OFFSET_WIDTH-1:0];

  assign capture = (state_q == ST_IDLE) && miss_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      fill_q    <= '0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        fill_q.way <= victim_way_i;
        fill_q.set <= miss_addr_i[SET_LO +: SET_SIZE];
        fill_q.tag <= miss_addr_i[TAG_LO +: TAG_SIZE];
        wb_tag_q   <= victim_tag_i;
        wb_data_q  <= victim_data_i;
      end
      if (state_q == ST_REFILL && mem.ready)
        fill_q.data <= mem.rdata;
    end
  end

  // Request signals decode only the registered state, so they are glitch-free
  // and hold steady while memory stalls.
  always_comb begin
    state_d   = state_q;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (miss_i) state_d = victim_dirty_i ? ST_WRITEBACK : ST_REFILL;
      end
      ST_WRITEBACK: begin
        mem.req   = 1'b1;
        mem.we    = 1'b1;
        mem.addr  = word_addr(wb_tag_q, fill_q.set);
        mem.wdata = wb_data_q;
        if (mem.ready) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        mem.req  = 1'b1;
        mem.addr = word_addr(fill_q.tag, fill_q.set);
        if (mem.ready) state_d = ST_FILL;
      end
      ST_FILL: state_d = ST_DONE;
      // Turnaround so the cache re-lookup sees the freshly written array.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign fill_valid_o = (state_q == ST_FILL);
  assign fill_way_o   = fill_q.way;
  assign fill_set_o   = fill_q.set;
  assign fill_tag_o   = fill_q.tag;
  assign fill_data_o  = fill_q.data;

  // Gated by reset so every output reads 0 while reset is held.
  assign stall_o = rst_ni & (miss_i | (state_q != ST_IDLE));

`ifdef CACHE_PERF_CNT_EN
  cache_perf_cnt u_perf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (1'b0),
    .miss_inc_i (capture),
    .wb_inc_i   ((state_q == ST_WRITEBACK) && mem.ready),
    .miss_cnt_o (perf_miss_o),
    .wb_cnt_o   (perf_wb_o)
  );
`else
  assign perf_miss_o = '0;
  assign perf_wb_o   = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        miss_i = 1'b0;
  logic [31:0] miss_addr_i = '0;
  logic        victim_way_i = 1'b0;
  logic        victim_dirty_i = 1'b0;
  logic [21:0] victim_tag_i = '0;
  logic [31:0] victim_data_i = '0;
  logic        fill_valid_o, fill_way_o, stall_o;
  logic [7:0]  fill_set_o;
  logic [21:0] fill_tag_o;
  logic [31:0] fill_data_o, perf_miss_o, perf_wb_o;

  cache_refill_ctrl_if mem_bus();

  cache_refill_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .victim_way_i(victim_way_i), .victim_dirty_i(victim_dirty_i),
    .victim_tag_i(victim_tag_i), .victim_data_i(victim_data_i),
    .fill_valid_o(fill_valid_o), .fill_way_o(fill_way_o), .fill_set_o(fill_set_o),
    .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o), .stall_o(stall_o),
    .mem(mem_bus), .perf_miss_o(perf_miss_o), .perf_wb_o(perf_wb_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- memory model + transaction log ----------------
  typedef struct { logic we; logic [31:0] addr, wdata, rdata; } txn_t;
  txn_t        mlog[$];
  int          mem_wait = 0;
  bit          force_en = 0;
  logic [31:0] force_rdata = '0;
  int          wcnt = 0;
  bit          holding = 0;
  logic        h_we;
  logic [31:0] h_addr, h_wdata;

  initial begin
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
  end

  // Accepts each request after mem_wait waiting cycles; while a request is
  // pending its address/direction/data must not move.
  always @(negedge clk) begin
    if (mem_bus.req === 1'b1) begin
      if (!holding) begin
        holding = 1; wcnt = 0;
        h_we = mem_bus.we; h_addr = mem_bus.addr; h_wdata = mem_bus.wdata;
      end else begin
        checks++;
        if (mem_bus.we !== h_we || mem_bus.addr !== h_addr || (h_we && mem_bus.wdata !== h_wdata)) begin
          errors++;
          $display("FAIL req_stable: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                   mem_bus.we, mem_bus.addr, mem_bus.wdata, h_we, h_addr, h_wdata);
        end
      end
      if (wcnt == mem_wait) begin
        mem_bus.ready = 1'b1;
        mem_bus.rdata = force_en ? force_rdata : $urandom;
        mlog.push_back('{h_we, h_addr, h_wdata, mem_bus.rdata});
        holding = 0;
      end else begin
        mem_bus.ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_bus.ready = 1'b0;
      holding = 0;
    end
  end

  // ---------------- stimulus ----------------
  int exp_miss = 0, exp_wb = 0;
  logic        g_way;
  logic [7:0]  g_set;
  logic [21:0] g_tag;
  logic [31:0] g_data;

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 1'b0; miss_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    exp_miss = 0; exp_wb = 0;
  endtask

  // Issues one miss and runs it to completion. Cycle numbers count from the
  // cycle miss_i is first presented (cycle 0). hold keeps miss_i high until
  // the controller is back in IDLE (so it is high during DONE).
  task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic way,
                          input logic [21:0] vtag, input logic [31:0] vdata,
                          input int w, input bit hold,
                          output int fill_n, output int idle_n, output int nfills);
    mlog.delete();
    mem_wait = w;
    @(posedge clk); #1;
    miss_i = 1'b1; miss_addr_i = addr; victim_dirty_i = dirty;
    victim_way_i = way; victim_tag_i = vtag; victim_data_i = vdata;
    exp_miss++; if (dirty) exp_wb++;
    fill_n = -1; idle_n = -1; nfills = 0;
    for (int n = 0; n < 200 && idle_n < 0; n++) begin
      @(negedge clk);
      if (fill_valid_o) begin
        nfills++;
        if (fill_n < 0) begin
          fill_n = n; g_way = fill_way_o; g_set = fill_set_o; g_tag = fill_tag_o; g_data = fill_data_o;
        end
      end
      if (n > 0 && !stall_o) idle_n = n;
      @(posedge clk); #1;
      if (n == 0) begin
        // Scramble captured inputs: must have no effect.
        miss_addr_i = $urandom; victim_tag_i = 22'($urandom); victim_data_i = $urandom;
        victim_way_i = ~way; victim_dirty_i = ~dirty;
        if (!hold) miss_i = 1'b0;
      end
      if (hold && fill_n >= 0 && n == fill_n + 1) miss_i = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++;
    if (fill_valid_o !== 0 || stall_o !== 0 || mem_bus.req !== 0 || mem_bus.we !== 0) begin
      errors++; $display("FAIL reset_ctl: got fv=%b st=%b req=%b we=%b want 0", fill_valid_o, stall_o, mem_bus.req, mem_bus.we);
    end
    checks++;
    if (mem_bus.addr !== 0 || mem_bus.wdata !== 0 || fill_data_o !== 0 || fill_tag_o !== 0 || fill_set_o !== 0) begin
      errors++; $display("FAIL reset_data: got addr=%h wd=%h fd=%h want 0", mem_bus.addr, mem_bus.wdata, fill_data_o);
    end
    checks++;
    if (perf_miss_o !== 0 || perf_wb_o !== 0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_miss_o, perf_wb_o);
    end
    do_reset();
  endtask

  task automatic test_clean_miss();
    int fn, idn, nf;
    force_en = 1; force_rdata = 32'hDEADBEEF;
    run_miss(32'h0000_1234, 1'b0, 1'b1, 22'h0, 32'h0, 0, 1'b1, fn, idn, nf);
    force_en = 0;
    checks++;
    if (mlog.size() !== 1 || mlog[0].we !== 1'b0 || mlog[0].addr !== 32'h0000_1234) begin
      errors++; $display("FAIL clean_read: got n=%0d want one read at 00001234", mlog.size());
    end
    checks++;
    if (nf !== 1 || g_set !== 8'h8D || g_tag !== 22'h000004 || g_data !== 32'hDEADBEEF || g_way !== 1'b1) begin
      errors++; $display("FAIL clean_fill: got n=%0d set=%h tag=%h data=%h way=%b want 1 8d 000004 deadbeef 1",
                         nf, g_set, g_tag, g_data, g_way);
    end
    checks++;
    if (fn !== 2 || idn !== 4) begin
      errors++; $display("FAIL clean_latency: got fill=%0d idle=%0d want 2 4", fn, idn);
    end
  endtask

  task automatic test_dirty_miss();
    int fn, idn, nf;
    run_miss(32'h0000_1234, 1'b1, 1'b0, 22'h3FFFFF, 32'hA5A5A5A5, 0, 1'b0, fn, idn, nf);
    checks++;
    if (mlog.size() !== 2) begin
      errors++; $display("FAIL dirty_count: got %0d want 2", mlog.size());
    end else begin
      checks++;
      if (mlog[0].we !== 1'b1 || mlog[0].addr !== 32'hFFFF_FE34 || mlog[0].wdata !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL dirty_wb: got we=%b addr=%h wd=%h want 1 fffffe34 a5a5a5a5",
                           mlog[0].we, mlog[0].addr, mlog[0].wdata);
      end
      checks++;
      if (mlog[1].we !== 1'b0 || mlog[1].addr !== 32'h0000_1234 || g_data !== mlog[1].rdata) begin
        errors++; $display("FAIL dirty_rd: got we=%b addr=%h fd=%h want 0 00001234 %h",
                           mlog[1].we, mlog[1].addr, g_data, mlog[1].rdata);
      end
    end
    checks++;
    if (nf !== 1 || fn !== 3 || idn !== 5) begin
      errors++; $display("FAIL dirty_fill: got n=%0d fill=%0d idle=%0d want 1 3 5", nf, fn, idn);
    end
  endtask

  task automatic test_mem_wait();
    int fn, idn, nf;
    run_miss(32'h0BAD_F00C, 1'b1, 1'b1, 22'h12345, 32'h0123_4567, 3, 1'b0, fn, idn, nf);
    checks++;
    if (mlog.size() !== 2 || nf !== 1) begin
      errors++; $display("FAIL wait_count: got txn=%0d fills=%0d want 2 1", mlog.size(), nf);
    end
    checks++;
    if (fn !== 9 || idn !== 11) begin
      errors++; $display("FAIL wait_latency: got fill=%0d idle=%0d want 9 11", fn, idn);
    end
  endtask

  // Pulsed and held miss_i, random addresses, victims and memory delays.
  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      int fn, idn, nf, w, exp_fill;
      logic [31:0] a, vd;
      logic [21:0] vt;
      logic d, wy;
      a = $urandom; vd = $urandom; vt = 22'($urandom);
      d = 1'($urandom); wy = 1'($urandom); w = $urandom_range(0, 3);
      run_miss(a, d, wy, vt, vd, w, 1'(it & 1), fn, idn, nf);
      exp_fill = 1 + (d ? w + 1 : 0) + (w + 1);
      checks++;
      if (mlog.size() !== (d ? 2 : 1)) begin
        errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", it, mlog.size(), d ? 2 : 1);
      end else begin
        checks++;
        if (d && (mlog[0].we !== 1'b1 || mlog[0].addr !== {vt, a[9:2], 2'b00} || mlog[0].wdata !== vd)) begin
          errors++; $display("FAIL rnd_wb[%0d]: got addr=%h wd=%h want %h %h",
                             it, mlog[0].addr, mlog[0].wdata, {vt, a[9:2], 2'b00}, vd);
        end
        if (mlog[mlog.size()-1].we !== 1'b0 || mlog[mlog.size()-1].addr !== {a[31:2], 2'b00}) begin
          errors++; $display("FAIL rnd_rd[%0d]: got addr=%h want %h", it, mlog[mlog.size()-1].addr, {a[31:2], 2'b00});
        end
        checks++;
        if (nf !== 1 || g_way !== wy || g_set !== a[9:2] || g_tag !== a[31:10] || g_data !== mlog[mlog.size()-1].rdata) begin
          errors++; $display("FAIL rnd_fill[%0d]: got n=%0d way=%b set=%h tag=%h data=%h want 1 %b %h %h %h",
                             it, nf, g_way, g_set, g_tag, g_data, wy, a[9:2], a[31:10], mlog[mlog.size()-1].rdata);
        end
      end
      checks++;
      if (fn !== exp_fill || idn !== exp_fill + 2) begin
        errors++; $display("FAIL rnd_latency[%0d]: got fill=%0d idle=%0d want %0d %0d", it, fn, idn, exp_fill, exp_fill + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nf = 0;
    mem_wait = 100000;
    @(posedge clk); #1;
    miss_i = 1'b1; miss_addr_i = 32'h0000_5678; victim_dirty_i = 1'b0;
    @(posedge clk); #1 miss_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (mem_bus.req !== 1'b1 || stall_o !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got req=%b stall=%b want 1 1", mem_bus.req, stall_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (mem_bus.req !== 1'b0 || stall_o !== 1'b0 || fill_valid_o !== 1'b0) begin
      errors++; $display("FAIL mid_async: got req=%b stall=%b fv=%b want 0 0 0", mem_bus.req, stall_o, fill_valid_o);
    end
    @(posedge clk); #1 rst_ni = 1'b1;
    exp_miss = 0; exp_wb = 0;
    mem_wait = 0;
    repeat (5) begin
      @(negedge clk);
      if (fill_valid_o || stall_o || mem_bus.req) nf++;
    end
    checks++;
    if (nf !== 0) begin
      errors++; $display("FAIL mid_idle: got %0d busy cycles after release want 0", nf);
    end
  endtask

  task automatic test_perf();
    int fn, idn, nf;
    logic [31:0] want_m, want_w;
    do_reset();
    run_miss(32'h0000_0100, 1'b0, 1'b0, 22'h0, 32'h0, 0, 1'b0, fn, idn, nf);
    run_miss(32'h0000_0204, 1'b1, 1'b1, 22'h00AAA, 32'h5555_AAAA, 1, 1'b0, fn, idn, nf);
    run_miss(32'h0000_0308, 1'b0, 1'b0, 22'h0, 32'h0, 2, 1'b1, fn, idn, nf);
`ifdef CACHE_PERF_CNT_EN
    want_m = 32'(exp_miss); want_w = 32'(exp_wb);
`else
    want_m = 0; want_w = 0;
`endif
    @(negedge clk);
    checks++;
    if (perf_miss_o !== want_m || perf_wb_o !== want_w) begin
      errors++; $display("FAIL perf: got miss=%0d wb=%0d want %0d %0d", perf_miss_o, perf_wb_o, want_m, want_w);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_mem_wait();
    test_random();
    test_reset_mid();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
